// File: rtl/johnson_phase_monitor.sv
// johnson_phase_monitor: decodes a Johnson counter state into phase index/one-hot,
// flags illegal codes and out-of-order steps, and counts completed revolutions.
module johnson_phase_monitor #(
  parameter int WIDTH = 4,
  parameter int PH_W  = 3,
  parameter int REV_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               jc_vld,
  input  logic [WIDTH-1:0]   jc_in,
  input  logic               clr_err,
  output logic [PH_W-1:0]    phase,
  output logic [2*WIDTH-1:0] phase_oh,
  output logic               ph_vld,
  output logic               rev_tick,
  output logic [REV_W-1:0]   rev_cnt,
  output logic               illegal,
  output logic               seq_err,
  output logic [1:0]         err_sticky
);
  localparam int N = 2 * WIDTH;
  localparam logic [PH_W-1:0] LAST = PH_W'(N - 1);
  logic [PH_W-1:0]  phase_q, phase_d, pop, ph_new, succ;
  logic [N-1:0]     oh_q, oh_d;
  logic             vld_q, vld_d, tick_q, tick_d, ill_q, ill_d, seq_q, seq_d;
  logic [REV_W-1:0] rev_q, rev_d;
  logic [1:0]       sticky_q, sticky_d;
  logic             th_hi, th_lo, legal;
  always_comb begin
    pop   = '0;
    th_hi = 1'b1;
    th_lo = 1'b1;
    for (int i = 0; i < WIDTH; i++) pop = pop + PH_W'(jc_in[i]);
    for (int i = 0; i < WIDTH - 1; i++) begin
      th_hi = th_hi & (~jc_in[i] | jc_in[i+1]);
      th_lo = th_lo & (~jc_in[i+1] | jc_in[i]);
    end
    legal  = th_hi | th_lo;
    ph_new = (jc_in[WIDTH-1] || !(|jc_in)) ? pop : PH_W'(N - int'(pop));
    succ   = (phase_q == LAST) ? '0 : phase_q + PH_W'(1);
  end
  // ph_vld doubles as the sync flag: both are set by legal and cleared by illegal samples
  always_comb begin
    phase_d = phase_q;
    vld_d   = vld_q;
    rev_d   = rev_q;
    tick_d  = 1'b0;
    ill_d   = 1'b0;
    seq_d   = 1'b0;
    if (jc_vld && !legal) begin
      ill_d = 1'b1;
      vld_d = 1'b0;
    end else if (jc_vld) begin
      phase_d = ph_new;
      vld_d   = 1'b1;
      seq_d   = vld_q && (ph_new != succ);
      tick_d  = vld_q && (ph_new == succ) && (phase_q == LAST);
      rev_d   = rev_q + REV_W'(tick_d);
    end
    sticky_d = (clr_err ? 2'b00 : sticky_q) | {seq_d, ill_d};
    oh_d     = vld_d ? (N'(1) << phase_d) : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q  <= '0;
      oh_q     <= '0;
      vld_q    <= 1'b0;
      tick_q   <= 1'b0;
      ill_q    <= 1'b0;
      seq_q    <= 1'b0;
      rev_q    <= '0;
      sticky_q <= 2'b00;
    end else begin
      phase_q  <= phase_d;
      oh_q     <= oh_d;
      vld_q    <= vld_d;
      tick_q   <= tick_d;
      ill_q    <= ill_d;
      seq_q    <= seq_d;
      rev_q    <= rev_d;
      sticky_q <= sticky_d;
    end
  end
  assign phase      = phase_q;
  assign phase_oh   = oh_q;
  assign ph_vld     = vld_q;
  assign rev_tick   = tick_q;
  assign rev_cnt    = rev_q;
  assign illegal    = ill_q;
  assign seq_err    = seq_q;
  assign err_sticky = sticky_q;
endmodule

// File: tb/tb_johnson_phase_monitor.sv
// tb_johnson_phase_monitor: table-driven directed check of the phase monitor,
// with a second REV_W=2 instance sharing the stimulus to observe counter wrap.
module tb_johnson_phase_monitor;
  logic       clk = 1'b0, rst = 1'b0, jc_vld = 1'b0, clr_err = 1'b0;
  logic [3:0] jc_in = 4'b0;
  logic [2:0] phase_a, phase_b;
  logic [7:0] oh_a, oh_b, rev_a;
  logic [1:0] rev_b, st_a, st_b;
  logic       pv_a, pv_b, tk_a, tk_b, il_a, il_b, sq_a, sq_b;
  johnson_phase_monitor #(.WIDTH(4), .PH_W(3), .REV_W(8)) dut_a (
    .clk(clk), .rst(rst), .jc_vld(jc_vld), .jc_in(jc_in), .clr_err(clr_err),
    .phase(phase_a), .phase_oh(oh_a), .ph_vld(pv_a), .rev_tick(tk_a), .rev_cnt(rev_a),
    .illegal(il_a), .seq_err(sq_a), .err_sticky(st_a));
  johnson_phase_monitor #(.WIDTH(4), .PH_W(3), .REV_W(2)) dut_b (
    .clk(clk), .rst(rst), .jc_vld(jc_vld), .jc_in(jc_in), .clr_err(clr_err),
    .phase(phase_b), .phase_oh(oh_b), .ph_vld(pv_b), .rev_tick(tk_b), .rev_cnt(rev_b),
    .illegal(il_b), .seq_err(sq_b), .err_sticky(st_b));
  always #5 clk = ~clk;
  typedef struct {
    logic       vld;
    logic [3:0] jc;
    logic       clr;
    logic [2:0] ph;
    logic       pv, tk, il, sq;
    logic [1:0] st;
    logic [7:0] rev;
  } vec_t;
  vec_t       tbl[128];
  int         n = 0, split = 0, checks = 0, errors = 0;
  logic [3:0] code[8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};
  task automatic add(input logic v, input logic [3:0] j, input logic c, input int ph,
                     input logic pv, input logic tk, input logic il, input logic sq,
                     input logic [1:0] st, input int rev);
    tbl[n] = '{v, j, c, 3'(ph), pv, tk, il, sq, st, 8'(rev)};
    n++;
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  function automatic logic [63:0] pack_a();
    return 64'({phase_a, oh_a, pv_a, tk_a, il_a, sq_a, st_a, rev_a});
  endfunction
  function automatic logic [63:0] pack_b();
    return 64'({phase_b, oh_b, pv_b, tk_b, il_b, sq_b, st_b, rev_b});
  endfunction
  task automatic run_rows(input int lo, input int hi);
    logic [7:0] oh;
    for (int r = lo; r < hi; r++) begin
      jc_vld  = tbl[r].vld;
      jc_in   = tbl[r].jc;
      clr_err = tbl[r].clr;
      @(posedge clk);
      #1;
      oh = tbl[r].pv ? (8'b1 << tbl[r].ph) : 8'b0;
      chk($sformatf("row%0d_a", r), pack_a(),
          64'({tbl[r].ph, oh, tbl[r].pv, tbl[r].tk, tbl[r].il, tbl[r].sq, tbl[r].st, tbl[r].rev}));
      chk($sformatf("row%0d_b", r), pack_b(),
          64'({tbl[r].ph, oh, tbl[r].pv, tbl[r].tk, tbl[r].il, tbl[r].sq, tbl[r].st, tbl[r].rev[1:0]}));
    end
    jc_vld  = 1'b0;
    clr_err = 1'b0;
  endtask
  initial begin
    int rev;
    for (int k = 0; k < 8; k++) add(1, code[k], 0, k, 1, 0, 0, 0, 2'b00, 0);
    rev = 0;
    for (int r = 0; r < 5; r++)
      for (int k = 0; k < 8; k++) begin
        if (k == 0) rev++;
        add(1, code[k], 0, k, 1, k == 0, 0, 0, 2'b00, rev);
      end
    add(0, 4'b1010, 0, 7, 1, 0, 0, 0, 2'b00, 5);
    add(1, 4'b0000, 0, 0, 1, 1, 0, 0, 2'b00, 6);
    add(1, 4'b1000, 0, 1, 1, 0, 0, 0, 2'b00, 6);
    add(1, 4'b1010, 0, 1, 0, 0, 1, 0, 2'b01, 6);
    add(1, 4'b1100, 0, 2, 1, 0, 0, 0, 2'b01, 6);
    add(1, 4'b1110, 0, 3, 1, 0, 0, 0, 2'b01, 6);
    add(0, 4'b0000, 1, 3, 1, 0, 0, 0, 2'b00, 6);
    add(1, 4'b1111, 0, 4, 1, 0, 0, 0, 2'b00, 6);
    add(1, 4'b1000, 0, 1, 1, 0, 0, 1, 2'b10, 6);
    add(1, 4'b1110, 0, 3, 1, 0, 0, 1, 2'b10, 6);
    add(1, 4'b1110, 1, 3, 1, 0, 0, 1, 2'b10, 6);
    add(0, 4'b0000, 1, 3, 1, 0, 0, 0, 2'b00, 6);
    add(1, 4'b0101, 1, 3, 0, 0, 1, 0, 2'b01, 6);
    add(1, 4'b0111, 0, 5, 1, 0, 0, 0, 2'b01, 6);
    add(1, 4'b0011, 0, 6, 1, 0, 0, 0, 2'b01, 6);
    add(1, 4'b0001, 0, 7, 1, 0, 0, 0, 2'b01, 6);
    add(1, 4'b0000, 0, 0, 1, 1, 0, 0, 2'b01, 7);
    add(1, 4'b1000, 0, 1, 1, 0, 0, 0, 2'b01, 7);
    split = n;
    add(1, 4'b1100, 0, 2, 1, 0, 0, 0, 2'b00, 0);
    add(1, 4'b1110, 0, 3, 1, 0, 0, 0, 2'b00, 0);
    add(1, 4'b0000, 0, 0, 1, 0, 0, 1, 2'b10, 0);
    add(1, 4'b0001, 0, 7, 1, 0, 0, 1, 2'b10, 0);
    add(1, 4'b0000, 0, 0, 1, 1, 0, 0, 2'b10, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", pack_a(), 64'd0);
    chk("reset_b", pack_b(), 64'd0);
    rst = 1'b1;
    run_rows(0, split);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_a", pack_a(), 64'd0);
    chk("async_rst_b", pack_b(), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    run_rows(split, n);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
